vram_blit_engine: RTL and testbench



---
 rtl/vram_blit_engine.sv | 201 ++++++++++++++++++++
 tb/tb_vram_blit_engine.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_blit_engine.sv
// VRAM blit engine: clear-all, clear-line, scroll-up and fill-all over dedicated VRAM ports.
// Optional abort input is enabled by defining BLIT_ABORT_EN.
module vram_blit_engine #(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 30,
  parameter logic [7:0]  CLEAR_VALUE = 8'h20,
  localparam int unsigned XW = $clog2(COLS),
  localparam int unsigned YW = $clog2(ROWS),
  localparam int unsigned AW = XW + YW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [YW-1:0] cmd_row,
  input  logic [7:0]    cmd_value,
  input  logic          stall,
  output logic          vram_we,
  output logic [AW-1:0] vram_waddr,
  output logic [7:0]    vram_wdata,
  output logic          vram_re,
  output logic [AW-1:0] vram_raddr,
  input  logic [7:0]    vram_rdata,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef BLIT_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam logic [1:0] OP_CLEAR_ALL  = 2'd0;
  localparam logic [1:0] OP_CLEAR_LINE = 2'd1;
  localparam logic [1:0] OP_SCROLL_UP  = 2'd2;
  localparam logic [1:0] OP_FILL_ALL   = 2'd3;

  localparam logic [XW-1:0] COL_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(ROWS - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_COPY, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] wcol_q, wcol_d, rcol_q, rcol_d;
  logic [YW-1:0] wrow_q, wrow_d, rrow_q, rrow_d, last_q, last_d;
  logic [7:0]    fill_q, fill_d, hold_data_q, hold_data_d;
  logic          err_q, err_d, rd_pend_q, rd_pend_d, hold_v_q, hold_v_d;
  logic          line_bad;

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign cmd_ready  = ~busy;
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_DONE) && err_q;
  assign vram_waddr = {wrow_q, wcol_q};
  assign vram_raddr = {rrow_q, rcol_q};
  assign line_bad   = 32'(cmd_row) >= ROWS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wcol_q      <= '0;
      wrow_q      <= '0;
      rcol_q      <= '0;
      rrow_q      <= '0;
      last_q      <= '0;
      fill_q      <= CLEAR_VALUE;
      hold_data_q <= '0;
      err_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      hold_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcol_q      <= wcol_d;
      wrow_q      <= wrow_d;
      rcol_q      <= rcol_d;
      rrow_q      <= rrow_d;
      last_q      <= last_d;
      fill_q      <= fill_d;
      hold_data_q <= hold_data_d;
      err_q       <= err_d;
      rd_pend_q   <= rd_pend_d;
      hold_v_q    <= hold_v_d;
    end
  end

  // Next state, counters and strobes; rrow/rcol address the source row of a copy.
  always_comb begin
    state_d     = state_q;
    wcol_d      = wcol_q;
    wrow_d      = wrow_q;
    rcol_d      = rcol_q;
    rrow_d      = rrow_q;
    last_d      = last_q;
    fill_d      = fill_q;
    hold_data_d = hold_data_q;
    err_d       = err_q;
    hold_v_d    = hold_v_q;
    rd_pend_d   = 1'b0;
    vram_we     = 1'b0;
    vram_re     = 1'b0;
    vram_wdata  = fill_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (cmd_valid) begin
          wcol_d   = '0;
          wrow_d   = '0;
          rcol_d   = '0;
          rrow_d   = '0;
          last_d   = ROW_LAST;
          fill_d   = CLEAR_VALUE;
          err_d    = 1'b0;
          hold_v_d = 1'b0;
          state_d  = S_FILL;
          case (cmd_op)
            OP_CLEAR_ALL: begin
            end
            OP_CLEAR_LINE: begin
              if (line_bad) begin
                state_d = S_DONE;
                err_d   = 1'b1;
              end else begin
                wrow_d = cmd_row;
                last_d = cmd_row;
              end
            end
            OP_SCROLL_UP: begin
              rrow_d  = YW'(1);
              state_d = S_COPY;
            end
            OP_FILL_ALL: fill_d = cmd_value;
            default: begin
            end
          endcase
        end
      end

      S_FILL: begin
        if (!stall) begin
          vram_we = 1'b1;
          if (wcol_q == COL_LAST) begin
            wcol_d = '0;
            if (wrow_q == last_q) state_d = S_DONE;
            else                  wrow_d  = wrow_q + YW'(1);
          end else begin
            wcol_d = wcol_q + XW'(1);
          end
        end
      end

      S_COPY, S_DRAIN: begin
        vram_wdata = hold_v_q ? hold_data_q : vram_rdata;
        if (stall) begin
          // Read data returning into a stalled cycle is parked until the port frees up.
          if (rd_pend_q) begin
            hold_v_d    = 1'b1;
            hold_data_d = vram_rdata;
          end
        end else begin
          if (hold_v_q || rd_pend_q) begin
            vram_we  = 1'b1;
            hold_v_d = 1'b0;
            if (wcol_q == COL_LAST) begin
              wcol_d = '0;
              wrow_d = wrow_q + YW'(1);
            end else begin
              wcol_d = wcol_q + XW'(1);
            end
          end
          if (state_q == S_COPY) begin
            vram_re   = 1'b1;
            rd_pend_d = 1'b1;
            if (rcol_q == COL_LAST) begin
              rcol_d = '0;
              if (rrow_q == ROW_LAST) state_d = S_DRAIN;
              else                    rrow_d  = rrow_q + YW'(1);
            end else begin
              rcol_d = rcol_q + XW'(1);
            end
          end else if (hold_v_q || rd_pend_q) begin
            state_d = S_FILL;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef BLIT_ABORT_EN
    if (abort && busy) begin
      state_d   = S_DONE;
      err_d     = 1'b1;
      hold_v_d  = 1'b0;
      rd_pend_d = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_vram_blit_engine.sv
// Self-checking bench for vram_blit_engine: VRAM model, write scoreboard, command vector table.
module tb_vram_blit_engine;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [7:0] CLR = 8'h20;
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int AW = XW + YW;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [YW-1:0] cmd_row = '0;
  logic [7:0]    cmd_value = 8'h00;
  logic          stall = 1'b0;
  logic          vram_we;
  logic [AW-1:0] vram_waddr;
  logic [7:0]    vram_wdata;
  logic          vram_re;
  logic [AW-1:0] vram_raddr;
  logic [7:0]    vram_rdata = 8'h00;
  logic          busy;
  logic          done;
  logic          err;
`ifdef BLIT_ABORT_EN
  logic          abort = 1'b0;
`endif

  vram_blit_engine #(.COLS(COLS), .ROWS(ROWS), .CLEAR_VALUE(CLR)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_value(cmd_value), .stall(stall),
    .vram_we(vram_we), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
    .vram_re(vram_re), .vram_raddr(vram_raddr), .vram_rdata(vram_rdata),
    .busy(busy), .done(done), .err(err)
`ifdef BLIT_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    logic [1:0] op; int row; logic [7:0] val; bit stl; bit pre;
    int n_wr; int done_cyc; bit e;
  } vec_t;

  wr_t        exp_q[$];
  wr_t        got;
  logic [7:0] mem  [0:MEMSZ-1];
  logic [7:0] fe   [0:MEMSZ-1];
  logic [7:0] snap [0:MEMSZ-1];
  vec_t       vecs [8];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         wr_cnt = 0;
  int         edge_cnt = 0;
  int         e0 = 0;
  bit         stall_on = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int r, input int c);
    logic [YW-1:0] rr = YW'(r);
    logic [XW-1:0] cc = XW'(c);
    return {rr, cc};
  endfunction

  // VRAM model: 1-cycle read latency, garbage on the data bus when no read was issued
  always @(posedge clk) begin
    vram_rdata <= vram_re ? mem[vram_raddr] : 8'hEE;
    if (vram_we) mem[vram_waddr] = vram_wdata;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (vram_we || vram_re) check("strobe_in_stall", int'(stall), 0);
      if (vram_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", int'(vram_waddr), -1);
        end else begin
          got = exp_q.pop_front();
          check("waddr", int'(vram_waddr), int'(got.a));
          check("wdata", int'(vram_wdata), int'(got.d));
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    stall = stall_on && ($urandom_range(0, 99) < 30);
  end

  initial begin
    #3000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
    fe[a] = d;
  endtask

  task automatic fill_rows(input int r0, input int r1, input logic [7:0] d);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < COLS; c++) push(addr_of(r, c), d);
  endtask

  // Expected write sequence derived from current model contents
  task automatic plan(input logic [1:0] op, input int row, input logic [7:0] val);
    case (op)
      2'd0: fill_rows(0, ROWS - 1, CLR);
      2'd1: if (row < ROWS) fill_rows(row, row, CLR);
      2'd2: begin
        for (int r = 0; r < ROWS - 1; r++)
          for (int c = 0; c < COLS; c++) push(addr_of(r, c), mem[addr_of(r + 1, c)]);
        fill_rows(ROWS - 1, ROWS - 1, CLR);
      end
      default: fill_rows(0, ROWS - 1, val);
    endcase
  endtask

  task automatic preload();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mem[addr_of(r, c)] = 8'(r);
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== fe[i]) n++;
    return n;
  endfunction

  function automatic int snap_diff();
    int n = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== snap[i]) n++;
    return n;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [YW-1:0] row, input logic [7:0] val,
                       output int waited);
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_value = val;
    while (!cmd_ready && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    e0 = edge_cnt;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_row   = YW'($urandom);
    cmd_value = 8'($urandom);
  endtask

  task automatic wait_done(output int dc, output int de);
    int n = 0;
    dc = -1;
    de = -1;
    while (n < 20000) begin
      @(negedge clk);
      if (done) begin
        dc = edge_cnt - e0 + 1;
        de = int'(err);
        break;
      end
      n++;
    end
    if (dc < 0) check("done_timeout", n, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int dc, de, w;
    stall_on = v.stl;
    if (v.pre) preload();
    fe = mem;
    plan(v.op, v.row, v.val);
    wr_cnt = 0;
    issue(v.op, YW'(v.row), v.val, w);
    wait_done(dc, de);
    stall_on = 1'b0;
    if (v.done_cyc > 0) check("done_cycle", dc, v.done_cyc);
    check("err", de, int'(v.e));
    check("write_count", wr_cnt, v.n_wr);
    check("queue_left", exp_q.size(), 0);
    check("final_mem", mem_diff(), 0);
  endtask

  initial begin
    int dc, de, w, n;
    vecs[0] = '{2'd0,  0, 8'h00, 1'b0, 1'b0, 2400, 2401, 1'b0};
    vecs[1] = '{2'd1,  5, 8'h00, 1'b0, 1'b0,   80,   81, 1'b0};
    vecs[2] = '{2'd1, 31, 8'h00, 1'b0, 1'b0,    0,    1, 1'b1};
    vecs[3] = '{2'd2,  0, 8'h00, 1'b0, 1'b1, 2400, 2402, 1'b0};
    vecs[4] = '{2'd3,  0, 8'hAB, 1'b1, 1'b0, 2400,   -1, 1'b0};
    vecs[5] = '{2'd2,  0, 8'h00, 1'b1, 1'b1, 2400,   -1, 1'b0};
    vecs[6] = '{2'd1, 29, 8'h00, 1'b0, 1'b0,   80,   81, 1'b0};
    vecs[7] = '{2'd3,  0, 8'h00, 1'b0, 1'b0, 2400, 2401, 1'b0};
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_we", int'(vram_we), 0);
    check("rst_re", int'(vram_re), 0);
    check("rst_waddr", int'(vram_waddr), 0);
    check("rst_raddr", int'(vram_raddr), 0);
    check("rst_wdata", int'(vram_wdata), int'(CLR));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (i == 3) snap = mem;
      if (i == 5) check("scroll_stall_vs_clean", snap_diff(), 0);
    end

    // Second command offered while busy: held off, then accepted in the DONE cycle
    fe = mem;
    plan(2'd1, 3, 8'h00);
    plan(2'd1, 7, 8'h00);
    wr_cnt = 0;
    issue(2'd1, YW'(3), 8'h00, w);
    issue(2'd1, YW'(7), 8'h00, w);
    check("held_off_cycles", w, 80);
    wait_done(dc, de);
    check("second_done_cycle", dc, 81);
    check("two_line_writes", wr_cnt, 160);
    check("two_line_mem", mem_diff(), 0);

    // Asynchronous reset in the middle of a scroll
    preload();
    fe = mem;
    plan(2'd2, 0, 8'h00);
    wr_cnt = 0;
    issue(2'd2, '0, 8'h00, w);
    n = 0;
    while (wr_cnt < 500 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reached_mid_scroll", int'(wr_cnt >= 500), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", int'(vram_we), 0);
    check("arst_re", int'(vram_re), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_ready", int'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    run_vec(vecs[0]);

`ifdef BLIT_ABORT_EN
    fe = mem;
    plan(2'd0, 0, 8'h00);
    wr_cnt = 0;
    issue(2'd0, '0, 8'h00, w);
    n = 0;
    while (wr_cnt < 100 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    w = wr_cnt;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_done", int'(done), 1);
    check("abort_err", int'(err), 1);
    check("abort_no_we", int'(vram_we), 0);
    check("abort_writes", wr_cnt, w);
    exp_q.delete();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
